// File: rtl/aes_encrypt_iter_if.sv
// Valid/ready handshake bundle between plaintext producer, AES encrypt core and ciphertext consumer.
interface aes_encrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, ciphertext held until handshaked.
// Optional macro AES_ENC_KEY_LATCH_EN captures the whole round-key bus on accept.
module aes_encrypt_iter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [(Nr+1)*128-1:0] allKeys,
    aes_encrypt_iter_if.slave     bus
);
    localparam int KW = (Nr + 1) * Nk * 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] LAST_ROUND = 4'(Nr);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1:0]   fsm;
    logic [3:0]   round;
    logic [127:0] blk_p0;
    logic [127:0] ct_p1;
    logic [127:0] round_out;
    logic [KW-1:0] key_src;
    logic [127:0] round_key [0:Nr];
    logic         accept;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    // Multiply by x in GF(2^8), reduced modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k sits at [127-8k -: 8]; column c holds bytes 4c..4c+3 (rows 0..3).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] = sbox(s[127-8*(4*((c+w)%4)+w) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    assign accept = (fsm == IDLE) && bus.in_valid;

`ifdef AES_ENC_KEY_LATCH_EN
    logic [KW-1:0] key_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_reg <= '0;
        end else if (accept) begin
            key_reg <= allKeys;
        end
    end

    assign key_src = key_reg;
`else
    // Without key storage the producer must hold allKeys until the block reaches DONE.
    assign key_src = allKeys;
`endif

    always_comb begin
        for (int i = 0; i <= Nr; i++) begin
            round_key[i] = key_src[KW-1-i*128 -: 128];
        end
    end

    always_comb begin
        round_out = sub_shift(blk_p0);
        if (round != LAST_ROUND) begin
            round_out = mix_columns(round_out);
        end
        round_out = round_out ^ round_key[round];
    end

    // Round state register: initial AddRoundKey on accept, one full round per ROUND cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            blk_p0 <= bus.data_in ^ allKeys[KW-1 -: 128];
        end else if (fsm == ROUND) begin
            blk_p0 <= round_out;
        end
    end

    // Control and ciphertext output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm   <= IDLE;
            round <= 4'd0;
            ct_p1 <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        fsm   <= ROUND;
                        round <= 4'd1;
                    end
                end
                ROUND: begin
                    if (round == LAST_ROUND) begin
                        fsm   <= DONE;
                        ct_p1 <= round_out;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (fsm == IDLE);
    assign bus.out_valid = (fsm == DONE);
    assign bus.busy      = (fsm == ROUND) || (fsm == DONE);
    assign bus.data_out  = ct_p1;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed and randomized bench for aes_encrypt_iter against a byte-array AES-128 model.
module tb_aes_encrypt_iter;
    localparam int NR = 10;
    localparam int KW = (NR + 1) * 128;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic          clk = 1'b0;
    logic          reset;
    logic [KW-1:0] all_keys;

    aes_encrypt_iter_if bus();

    aes_encrypt_iter #(.Nk(4), .Nr(NR)) dut (
        .clk    (clk),
        .reset  (reset),
        .allKeys(all_keys),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]    sb [0:255];
    logic [31:0]   kw [0:43];
    logic [KW-1:0] k1, k2, kr;
    logic [127:0]  ct, pt, key, expct;
    int            lat;
    int            e, acc_n, got;
    int            acc [0:3];
    int            done_e [0:1];
    logic [127:0]  res [0:1];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // S-box derived from the field inverse plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) kw[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = kw[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            kw[i] = kw[i-4] ^ t;
        end
    endtask

    function automatic logic [KW-1:0] pack_keys();
        logic [KW-1:0] k;
        for (int i = 0; i < 44; i++) k[KW-1-32*i -: 32] = kw[i];
        return k;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] p);
        logic [7:0]   st [0:15];
        logic [7:0]   tmp [0:15];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) st[i] = p[127-8*i -: 8] ^ kw[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    tmp[w+4*c] = st[w+4*((c+w)%4)];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    if (rnd < NR)
                        st[4*c+w] = gf_mul(8'h02, tmp[4*c+w]) ^ gf_mul(8'h03, tmp[4*c+(w+1)%4]) ^
                                    tmp[4*c+(w+2)%4] ^ tmp[4*c+(w+3)%4];
                    else
                        st[4*c+w] = tmp[4*c+w];
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ kw[4*rnd+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = st[i];
        return r;
    endfunction

    // Presents one block at a negedge where the core is idle; returns edges-to-valid and the result.
    task automatic enc(input logic [127:0] p, input logic [KW-1:0] keys, input bit scramble,
                       output int l, output logic [127:0] c);
        bus.data_in  = p;
        all_keys     = keys;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        l = 0;
        while (bus.out_valid !== 1'b1 && l < 40) begin
            if (scramble) for (int i = 0; i < KW / 32; i++) all_keys[32*i +: 32] = $urandom;
            @(negedge clk);
            l++;
        end
        c = bus.data_out;
    endtask

    initial begin
        build_sbox();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        all_keys      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_data_out", bus.data_out, 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);

        expand(K1);
        k1 = pack_keys();
        expct = model_enc(P1);
        expand(K2);
        k2 = pack_keys();

        enc(P1, k1, 1'b0, lat, ct);
        chk("c1_latency", 128'(lat), 128'd10);
        chk("c1_const", ct, C1);
        chk("c1_model", ct, expct);

        // Hold in DONE with out_ready low while a competing block is offered.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
            chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_data_out", bus.data_out, C1);
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_out_valid", 128'(bus.out_valid), 128'd0);
        chk("bp_rel_in_ready", 128'(bus.in_ready), 128'd1);
        chk("bp_rel_data_kept", bus.data_out, C1);
        chk("bp_rel_busy", 128'(bus.busy), 128'd0);

        enc(P2, k2, 1'b0, lat, ct);
        chk("c2_latency", 128'(lat), 128'd10);
        chk("c2_const", ct, C2);
        @(negedge clk);
        chk("c2_out_valid_drop", 128'(bus.out_valid), 128'd0);

        // Back-to-back with in_valid held high throughout.
        e = 0; acc_n = 0; got = 0;
        bus.data_in  = P1;
        all_keys     = k1;
        bus.in_valid = 1'b1;
        while (got < 2 && e < 60) begin
            if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1 && acc_n < 4) begin
                acc[acc_n] = e + 1;
                acc_n++;
            end
            @(negedge clk);
            e++;
            if (bus.out_valid === 1'b1) begin
                res[got]    = bus.data_out;
                done_e[got] = e;
                got++;
                if (got == 1) begin
                    bus.data_in = P2;
                    all_keys    = k2;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
        chk("b2b_results", 128'(got), 128'd2);
        chk("b2b_accepts", 128'(acc_n), 128'd2);
        chk("b2b_interval", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b_latency", 128'(done_e[0] - acc[0]), 128'd10);
        chk("b2b_ct1", res[0], C1);
        chk("b2b_ct2", res[1], C2);
        @(negedge clk);

        // Abort in round 5, then a fresh block must still encrypt correctly.
        bus.data_in  = P1;
        all_keys     = k1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 128'(bus.busy), 128'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out_valid", 128'(bus.out_valid), 128'd0);
        chk("abort_in_ready", 128'(bus.in_ready), 128'd1);
        chk("abort_data_out", bus.data_out, 128'd0);
        chk("abort_busy", 128'(bus.busy), 128'd0);
        enc(P2, k2, 1'b0, lat, ct);
        chk("abort_c2", ct, C2);
        @(negedge clk);

`ifdef AES_ENC_KEY_LATCH_EN
        enc(P1, k1, 1'b1, lat, ct);
        chk("latch_c1", ct, C1);
        @(negedge clk);
`endif

        for (int n = 0; n < 6; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            expand(key);
            kr    = pack_keys();
            expct = model_enc(pt);
            enc(pt, kr, 1'b0, lat, ct);
            chk("rand_latency", 128'(lat), 128'd10);
            chk("rand_ct", ct, expct);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
